// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-path definitions: state encoding, bus widths and default reset address.
package cpu_fetch_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_ADDR = 16'h0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/prefetch_fifo.sv
// Circular storage of {addr,data} entries with push/pop/clear; the caller owns flow control.
module prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 16,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [AW-1:0]          push_addr,
    input  logic [DW-1:0]          push_data,
    output logic [AW-1:0]          head_addr,
    output logic [DW-1:0]          head_data,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [AW-1:0] addr_mem [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                addr_mem[i[PW-1:0]] <= '0;
                data_mem[i[PW-1:0]] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                addr_mem[wr_ptr] <= push_addr;
                data_mem[wr_ptr] <= push_data;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

endmodule

// File: rtl/cpu_prefetch_queue.sv
// Sequential instruction-byte prefetcher feeding the CPU core; flush redirects fetch.
// Define CPU_PREFETCH_WRAP_STOP_EN to halt fetching on address wrap and expose wrapFault.
module cpu_prefetch_queue
    import cpu_fetch_pkg::*;
#(
    parameter int                DEPTH      = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = DEFAULT_RESET_ADDR
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic [ADDR_W-1:0]      memAddress,
    output logic                   memRead,
    input  logic                   memReady,
    input  logic [DATA_W-1:0]      memDataIn,
    output logic [DATA_W-1:0]      byteOut,
    output logic [ADDR_W-1:0]      byteAddr,
    output logic                   byteValid,
    input  logic                   byteTake,
    input  logic                   flush,
    input  logic [ADDR_W-1:0]      flushAddress,
    output logic [$clog2(DEPTH):0] fillLevel
`ifdef CPU_PREFETCH_WRAP_STOP_EN
    ,
    output logic                   wrapFault
`endif
);

    localparam int            CW      = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] LAST_LV = CW'(DEPTH - 1);

    fetch_state_t      state;
    fetch_state_t      state_nxt;
    logic [ADDR_W-1:0] fetch_addr;
    logic              push;
    logic              pop;

    // flush wins over a same-cycle handshake or take: both are dropped
    assign push = memRead && memReady && !flush;
    assign pop  = byteTake && byteValid && !flush;

    assign memRead    = (state == ST_FETCH);
    assign memAddress = fetch_addr;
    assign byteValid  = (fillLevel != '0);

`ifdef CPU_PREFETCH_WRAP_STOP_EN
    assign wrapFault = (state == ST_HALT);
`endif

    // Reset parks in FLUSH so the first request issues one cycle after reset drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_FLUSH;
            fetch_addr <= RESET_ADDR;
        end else begin
            state <= state_nxt;
            if (flush) begin
                fetch_addr <= flushAddress;
            end else if (push) begin
                fetch_addr <= fetch_addr + 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (push && !pop && fillLevel == LAST_LV) begin
                        state_nxt = ST_FULL;
                    end
`ifdef CPU_PREFETCH_WRAP_STOP_EN
                    if (push && fetch_addr == '1) begin
                        state_nxt = ST_HALT;
                    end
`endif
                end
                ST_FULL: begin
                    if (pop) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FLUSH: state_nxt = ST_FETCH;
`ifdef CPU_PREFETCH_WRAP_STOP_EN
                ST_HALT:  state_nxt = ST_HALT;
`endif
                default:  state_nxt = ST_FETCH;
            endcase
        end
    end

    prefetch_fifo #(
        .DEPTH (DEPTH),
        .AW    (ADDR_W),
        .DW    (DATA_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (flush),
        .push      (push),
        .pop       (pop),
        .push_addr (fetch_addr),
        .push_data (memDataIn),
        .head_addr (byteAddr),
        .head_data (byteOut),
        .count     (fillLevel)
    );

endmodule

// File: tb/tb_cpu_prefetch_queue.sv
// Randomized and directed bench for cpu_prefetch_queue against a queue-based reference model.
module tb_cpu_prefetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] memAddress;
    logic        memRead;
    logic        memReady;
    logic [7:0]  memDataIn;
    logic [7:0]  byteOut;
    logic [15:0] byteAddr;
    logic        byteValid;
    logic        byteTake;
    logic        flush;
    logic [15:0] flushAddress;
    logic [2:0]  fillLevel;
`ifdef CPU_PREFETCH_WRAP_STOP_EN
    logic        wrapFault;
`endif

    int n_checks = 0;
    int n_errors = 0;

    // Model: queue of {addr,data}, next fetch address, one-cycle post-flush gap, wrap halt.
    logic [23:0] mq[$];
    logic [15:0] m_fa;
    logic        m_cool;
    logic        m_halt;

    always #5 clk = ~clk;

    cpu_prefetch_queue #(
        .DEPTH      (DEPTH),
        .RESET_ADDR (16'h0000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .memAddress   (memAddress),
        .memRead      (memRead),
        .memReady     (memReady),
        .memDataIn    (memDataIn),
        .byteOut      (byteOut),
        .byteAddr     (byteAddr),
        .byteValid    (byteValid),
        .byteTake     (byteTake),
        .flush        (flush),
        .flushAddress (flushAddress),
        .fillLevel    (fillLevel)
`ifdef CPU_PREFETCH_WRAP_STOP_EN
        ,
        .wrapFault    (wrapFault)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic rdy, input logic take, input logic fl, input logic [15:0] fa);
        memReady     = rdy;
        byteTake     = take;
        flush        = fl;
        flushAddress = fa;
        memDataIn    = 8'($urandom);
    endtask

    // Compare outputs with the model, advance the model with current inputs, then clock.
    task automatic step();
        logic        exp_rd;
        logic [23:0] e;
        exp_rd = !m_cool && !m_halt && (mq.size() < DEPTH);
        check_val("memRead", 32'(memRead), 32'(exp_rd));
        if (exp_rd) check_val("memAddress", 32'(memAddress), 32'(m_fa));
        check_val("fillLevel", 32'(fillLevel), mq.size());
        check_val("byteValid", 32'(byteValid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            e = mq[0];
            check_val("byteAddr", 32'(byteAddr), 32'(e[23:8]));
            check_val("byteOut", 32'(byteOut), 32'(e[7:0]));
        end
`ifdef CPU_PREFETCH_WRAP_STOP_EN
        check_val("wrapFault", 32'(wrapFault), 32'(m_halt));
`endif
        if (reset) begin
            mq.delete();
            m_fa   = 16'h0000;
            m_cool = 1'b1;
            m_halt = 1'b0;
        end else if (flush) begin
            mq.delete();
            m_fa   = flushAddress;
            m_cool = 1'b1;
            m_halt = 1'b0;
        end else begin
            m_cool = 1'b0;
            if (byteTake && mq.size() != 0) void'(mq.pop_front());
            if (exp_rd && memReady) begin
                mq.push_back({m_fa, memDataIn});
`ifdef CPU_PREFETCH_WRAP_STOP_EN
                if (m_fa == 16'hFFFF) m_halt = 1'b1;
`endif
                m_fa = m_fa + 16'h1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] wrap_addr [4];
        logic [15:0] held;
        wrap_addr[0] = 16'hFFFE;
        wrap_addr[1] = 16'hFFFF;
        wrap_addr[2] = 16'h0000;
        wrap_addr[3] = 16'h0001;

        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (2) @(posedge clk);
        #1;
        mq.delete();
        m_fa   = 16'h0000;
        m_cool = 1'b1;
        m_halt = 1'b0;
        check_val("rst_fill", 32'(fillLevel), 0);
        check_val("rst_valid", 32'(byteValid), 0);
        check_val("rst_memRead", 32'(memRead), 0);
        check_val("rst_byteOut", 32'(byteOut), 0);
        check_val("rst_byteAddr", 32'(byteAddr), 0);

        // Fill from reset: requests 0000..0003, then stall full
        reset = 1'b0;
        repeat (5) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            step();
        end
        check_val("fill_memRead", 32'(memRead), 0);
        check_val("fill_level", 32'(fillLevel), 4);
        check_val("fill_headAddr", 32'(byteAddr), 32'h0000);

        // Single take while full: request resumes at 0004
        drive(1'b1, 1'b1, 1'b0, 16'h0000);
        step();
        check_val("take_level", 32'(fillLevel), 3);
        check_val("take_memRead", 32'(memRead), 1);
        check_val("take_memAddr", 32'(memAddress), 32'h0004);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_val("refill_level", 32'(fillLevel), 4);

        // Wait states: address held, nothing pushed
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        held = memAddress;
        repeat (3) begin
            drive(1'b0, 1'b0, 1'b0, 16'h0000);
            step();
            check_val("wait_addr", 32'(memAddress), 32'(held));
            check_val("wait_level", 32'(fillLevel), 3);
        end
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();

        // Flush with simultaneous push and pop
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        drive(1'b1, 1'b1, 1'b1, 16'h1234);
        step();
        check_val("flush_level", 32'(fillLevel), 0);
        check_val("flush_valid", 32'(byteValid), 0);
        check_val("flush_memRead", 32'(memRead), 0);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_val("flush_req", 32'(memRead), 1);
        check_val("flush_reqAddr", 32'(memAddress), 32'h1234);
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_val("flush_headValid", 32'(byteValid), 1);
        check_val("flush_headAddr", 32'(byteAddr), 32'h1234);

        // Address wrap
        drive(1'b1, 1'b0, 1'b1, 16'hFFFE);
        step();
`ifdef CPU_PREFETCH_WRAP_STOP_EN
        repeat (3) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            step();
        end
        check_val("halt_fault", 32'(wrapFault), 1);
        check_val("halt_memRead", 32'(memRead), 0);
        check_val("halt_level", 32'(fillLevel), 2);
        for (int i = 0; i < 2; i++) begin
            check_val("halt_order", 32'(byteAddr), 32'(wrap_addr[i]));
            drive(1'b1, 1'b1, 1'b0, 16'h0000);
            step();
        end
        check_val("halt_drained", 32'(fillLevel), 0);
        check_val("halt_stays", 32'(memRead), 0);
        drive(1'b1, 1'b0, 1'b1, 16'h0010);
        step();
        check_val("halt_cleared", 32'(wrapFault), 0);
`else
        repeat (5) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            step();
        end
        check_val("wrap_level", 32'(fillLevel), 4);
        for (int i = 0; i < 4; i++) begin
            check_val("wrap_order", 32'(byteAddr), 32'(wrap_addr[i]));
            drive(1'b0, 1'b1, 1'b0, 16'h0000);
            step();
        end
`endif

        // Reset while a request is waiting on a non-empty queue
        drive(1'b1, 1'b0, 1'b1, 16'h0100);
        step();
        repeat (5) begin
            drive(1'b1, 1'b0, 1'b0, 16'h0000);
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 16'h0000);
        step();
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 16'h0000);
        step();
        check_val("mrst_level", 32'(fillLevel), 0);
        check_val("mrst_memRead", 32'(memRead), 0);
        reset = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 16'h0000);
        step();
        check_val("mrst_resume", 32'(memRead), 1);
        check_val("mrst_addr", 32'(memAddress), 32'h0000);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            logic [15:0] fa;
            fa = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                             : 16'($urandom);
            reset = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 39) == 0, fa);
            step();
        end
        reset = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
